// File: rtl/mode_pkg.sv
// Shared encodings for the calculator mode/operation sequencer.
package mode_pkg;

    localparam int OP_W = 2;

    typedef enum logic [1:0] {
        MODE_ARITH   = 2'd0,
        MODE_LOGIC   = 2'd1,
        MODE_COMPARE = 2'd2,
        MODE_MAGIC   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_e;

    function automatic mode_e next_mode(input mode_e m);
        return mode_e'(m + 2'd1);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronizes one active-low key, debounces it and emits a one-cycle press event.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_stable_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= key_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // The sample that completes the run flips the stable level.
            if (r_sync2 != r_stable) begin
                if (r_cnt == CNT_MAX) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_stable_d & ~r_stable;

endmodule

// File: rtl/mode_sequencer.sv
// Drives the datapath MODE/OPERATION selects from debounced keys, with an auto-scan demo state.
module mode_sequencer
    import mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DWELL_CYCLES    = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      key_n,
    input  logic [OP_W-1:0] sw_op,
    output logic [1:0]      mode,
    output logic [OP_W-1:0] operation,
    output logic            auto_active,
    output logic            step
);

    localparam int DW = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0]   DWELL_MAX = DW'(DWELL_CYCLES - 1);
    localparam logic [OP_W-1:0] OP_MAX    = '1;

    logic w_ev0;
    logic w_ev1;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n[0]),
        .press (w_ev0)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n[1]),
        .press (w_ev1)
    );

    state_e          r_state, w_state_n;
    mode_e           r_mode, w_mode_n;
    logic [OP_W-1:0] r_op, w_op_n;
    logic [DW-1:0]   r_dwell, w_dwell_n;
    mode_e           r_mode_prev;
    logic [OP_W-1:0] r_op_prev;
    logic            r_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_MANUAL;
            r_mode      <= MODE_ARITH;
            r_op        <= '0;
            r_dwell     <= '0;
            r_mode_prev <= MODE_ARITH;
            r_op_prev   <= '0;
            r_step      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_mode      <= w_mode_n;
            r_op        <= w_op_n;
            r_dwell     <= w_dwell_n;
            r_mode_prev <= r_mode;
            r_op_prev   <= r_op;
            r_step      <= (r_mode != r_mode_prev) || (r_op != r_op_prev);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_mode_n  = r_mode;
        w_op_n    = r_op;
        w_dwell_n = r_dwell;

        if (w_ev0) w_mode_n = next_mode(r_mode);

        unique case (r_state)
            ST_MANUAL: begin
                if (w_ev1) begin
                    w_state_n = ST_AUTO;
                    w_op_n    = '0;
                    w_dwell_n = '0;
                end else begin
                    w_op_n = sw_op;
                end
            end
            ST_AUTO: begin
                // Key events win over a dwell terminal count in the same cycle.
                if (w_ev1) begin
                    w_state_n = ST_MANUAL;
                    w_op_n    = sw_op;
                end else if (w_ev0) begin
                    w_op_n    = '0;
                    w_dwell_n = '0;
                end else if (r_dwell == DWELL_MAX) begin
                    w_dwell_n = '0;
                    w_op_n    = r_op + OP_W'(1);
                    if (r_op == OP_MAX) w_mode_n = next_mode(r_mode);
                end else begin
                    w_dwell_n = r_dwell + DW'(1);
                end
            end
            default: w_state_n = ST_MANUAL;
        endcase
    end

    assign mode        = r_mode;
    assign operation   = r_op;
    assign auto_active = (r_state == ST_AUTO);
    assign step        = r_step;

endmodule
